// File: rtl/wb_bus_mux_n.sv
// ============================================================================
// Module      : wb_bus_mux_n
// Description : Single-master Wishbone fan-out to NUM_PORTS downstream ports
//               with address decode, unmapped-access error response and an
//               optional downstream timeout (enable with WB_BUS_MUX_TIMEOUT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_bus_mux_n #(
    parameter int          NUM_PORTS      = 2,
    parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
    parameter logic [31:0] BASE_MASK      = 32'hFF00_0000,
    parameter int          SEL_LSB        = 20,
    parameter int          SEL_BITS       = 2,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] UNMAPPED_DATA  = 32'hDEAD_BEEF
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,

    input  logic                    wbs_ufp_stb_i,
    input  logic                    wbs_ufp_cyc_i,
    input  logic                    wbs_ufp_we_i,
    input  logic [3:0]              wbs_ufp_sel_i,
    input  logic [31:0]             wbs_ufp_dat_i,
    input  logic [31:0]             wbs_ufp_adr_i,
    output logic                    wbs_ufp_ack_o,
    output logic [31:0]             wbs_ufp_dat_o,

    output logic [NUM_PORTS-1:0]    wbs_dfp_stb_o,
    output logic [NUM_PORTS-1:0]    wbs_dfp_cyc_o,
    output logic                    wbs_dfp_we_o,
    output logic [3:0]              wbs_dfp_sel_o,
    output logic [31:0]             wbs_dfp_dat_o,
    output logic [31:0]             wbs_dfp_adr_o,
    input  logic [32*NUM_PORTS-1:0] wbs_dfp_dat_i,
    input  logic [NUM_PORTS-1:0]    wbs_dfp_ack_i,

    output logic                    bus_err_o
);

    localparam logic [1:0]          c_st_idle   = 2'd0;
    localparam logic [1:0]          c_st_busy   = 2'd1;
    localparam logic [1:0]          c_st_resp   = 2'd2;
    localparam logic [SEL_BITS:0]   c_num_ports = (SEL_BITS+1)'(NUM_PORTS);
    localparam logic [15:0]         c_tmo_last  = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]           r_state, w_state_nxt;
    logic [NUM_PORTS-1:0] r_cyc, w_cyc_nxt;
    logic                 r_we, w_we_nxt;
    logic [3:0]           r_sel, w_sel_nxt;
    logic [31:0]          r_dat, w_dat_nxt;
    logic [31:0]          r_adr, w_adr_nxt;
    logic [31:0]          r_rdata, w_rdata_nxt;
    logic                 r_err, w_err_nxt;

    logic                 w_req;
    logic                 w_hit;
    logic [SEL_BITS-1:0]  w_port;
    logic                 w_port_ok;
    logic [NUM_PORTS-1:0] w_onehot;
    logic                 w_sel_ack;
    logic [31:0]          w_sel_dat;
    logic                 w_tmo_hit;

    assign w_req     = wbs_ufp_cyc_i & wbs_ufp_stb_i;
    assign w_hit     = ((wbs_ufp_adr_i & BASE_MASK) == BASE_ADDR);
    assign w_port    = wbs_ufp_adr_i[SEL_LSB +: SEL_BITS];
    assign w_port_ok = ({1'b0, w_port} < c_num_ports);
    assign w_onehot  = NUM_PORTS'(1) << w_port;

    // r_cyc is one-hot on the active port, so masking with it selects that port's ack/data
    assign w_sel_ack = |(wbs_dfp_ack_i & r_cyc);

    always_comb begin
        w_sel_dat = 32'h0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (r_cyc[p]) begin
                w_sel_dat = w_sel_dat | wbs_dfp_dat_i[32*p +: 32];
            end
        end
    end

`ifdef WB_BUS_MUX_TIMEOUT_EN
    logic [15:0] r_tmo_cnt;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || (r_state != c_st_busy)) begin
            r_tmo_cnt <= 16'h0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 16'h1;
        end
    end

    assign w_tmo_hit = (r_tmo_cnt == c_tmo_last);
`else
    logic w_unused_tmo;
    assign w_unused_tmo = ^c_tmo_last;
    assign w_tmo_hit    = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cyc_nxt   = r_cyc;
        w_we_nxt    = r_we;
        w_sel_nxt   = r_sel;
        w_dat_nxt   = r_dat;
        w_adr_nxt   = r_adr;
        w_rdata_nxt = r_rdata;
        w_err_nxt   = 1'b0;

        case (r_state)
            c_st_idle: begin
                if (w_req) begin
                    if (w_hit && w_port_ok) begin
                        w_cyc_nxt   = w_onehot;
                        w_we_nxt    = wbs_ufp_we_i;
                        w_sel_nxt   = wbs_ufp_sel_i;
                        w_dat_nxt   = wbs_ufp_dat_i;
                        w_adr_nxt   = wbs_ufp_adr_i;
                        w_state_nxt = c_st_busy;
                    end else begin
                        w_rdata_nxt = UNMAPPED_DATA;
                        w_err_nxt   = 1'b1;
                        w_state_nxt = c_st_resp;
                    end
                end
            end
            c_st_busy: begin
                // master abort wins over a coincident downstream ack
                if (!wbs_ufp_cyc_i) begin
                    w_cyc_nxt   = '0;
                    w_state_nxt = c_st_idle;
                end else if (w_sel_ack) begin
                    w_cyc_nxt   = '0;
                    w_rdata_nxt = w_sel_dat;
                    w_state_nxt = c_st_resp;
                end else if (w_tmo_hit) begin
                    w_cyc_nxt   = '0;
                    w_rdata_nxt = UNMAPPED_DATA;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = c_st_resp;
                end
            end
            c_st_resp: begin
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_cyc_nxt   = '0;
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= c_st_idle;
            r_cyc   <= '0;
            r_we    <= 1'b0;
            r_sel   <= 4'h0;
            r_dat   <= 32'h0;
            r_adr   <= 32'h0;
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cyc   <= w_cyc_nxt;
            r_we    <= w_we_nxt;
            r_sel   <= w_sel_nxt;
            r_dat   <= w_dat_nxt;
            r_adr   <= w_adr_nxt;
            r_rdata <= w_rdata_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign wbs_ufp_ack_o = (r_state == c_st_resp);
    assign wbs_ufp_dat_o = wbs_ufp_ack_o ? r_rdata : 32'h0;
    assign bus_err_o     = r_err;

    assign wbs_dfp_stb_o = r_cyc;
    assign wbs_dfp_cyc_o = r_cyc;
    assign wbs_dfp_we_o  = r_we;
    assign wbs_dfp_sel_o = r_sel;
    assign wbs_dfp_dat_o = r_dat;
    assign wbs_dfp_adr_o = r_adr;

endmodule

`default_nettype wire

// File: tb/tb_wb_bus_mux_n.sv
// ============================================================================
// Module      : tb_wb_bus_mux_n
// Description : Directed self-checking bench for wb_bus_mux_n (two ports).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_bus_mux_n;

    logic        clk;
    logic        rst;
    logic        ufp_stb, ufp_cyc, ufp_we;
    logic [3:0]  ufp_sel;
    logic [31:0] ufp_dat_i, ufp_adr;
    logic        ufp_ack;
    logic [31:0] ufp_dat_o;
    logic [1:0]  dfp_stb, dfp_cyc;
    logic        dfp_we;
    logic [3:0]  dfp_sel;
    logic [31:0] dfp_dat_o, dfp_adr;
    logic [63:0] dfp_dat_i;
    logic [1:0]  dfp_ack;
    logic        bus_err;

    int n_chk  = 0;
    int n_pass = 0;

    wb_bus_mux_n #(
        .NUM_PORTS      (2),
        .TIMEOUT_CYCLES (8)
    ) u_dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .wbs_ufp_stb_i (ufp_stb),
        .wbs_ufp_cyc_i (ufp_cyc),
        .wbs_ufp_we_i  (ufp_we),
        .wbs_ufp_sel_i (ufp_sel),
        .wbs_ufp_dat_i (ufp_dat_i),
        .wbs_ufp_adr_i (ufp_adr),
        .wbs_ufp_ack_o (ufp_ack),
        .wbs_ufp_dat_o (ufp_dat_o),
        .wbs_dfp_stb_o (dfp_stb),
        .wbs_dfp_cyc_o (dfp_cyc),
        .wbs_dfp_we_o  (dfp_we),
        .wbs_dfp_sel_o (dfp_sel),
        .wbs_dfp_dat_o (dfp_dat_o),
        .wbs_dfp_adr_o (dfp_adr),
        .wbs_dfp_dat_i (dfp_dat_i),
        .wbs_dfp_ack_i (dfp_ack),
        .bus_err_o     (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // advance one clock and settle just past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                       input logic [3:0] sel);
        ufp_stb   = 1'b1;
        ufp_cyc   = 1'b1;
        ufp_we    = we;
        ufp_adr   = adr;
        ufp_dat_i = wdat;
        ufp_sel   = sel;
    endtask

    task automatic drop_req();
        ufp_stb   = 1'b0;
        ufp_cyc   = 1'b0;
        ufp_we    = 1'b0;
        ufp_adr   = 32'h0;
        ufp_dat_i = 32'h0;
        ufp_sel   = 4'h0;
    endtask

    // mapped transfer: downstream ack in cycle ack_cyc, upstream ack expected one cycle later
    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                        input logic [3:0] sel, input logic [1:0] exp_cyc, input int ack_cyc,
                        input logic [31:0] rdat, input logic stray);
        req(we, adr, wdat, sel);
        tick();
        chk("dfp_cyc", dfp_cyc, exp_cyc);
        chk("dfp_stb", dfp_stb, exp_cyc);
        chk("dfp_we",  dfp_we,  we);
        chk("dfp_sel", dfp_sel, sel);
        chk("dfp_dat", dfp_dat_o, wdat);
        chk("dfp_adr", dfp_adr, adr);
        chk("busy_noack", ufp_ack, 1'b0);
        if (stray) begin
            dfp_ack   = ~exp_cyc;
            dfp_dat_i = {32'hBAD1_1111, 32'hBAD0_0000};
            tick();
            dfp_ack   = 2'b00;
            chk("stray_noack", ufp_ack, 1'b0);
            chk("stray_cyc", dfp_cyc, exp_cyc);
        end
        for (int c = (stray ? 2 : 1); c < ack_cyc; c++) begin
            tick();
            chk("wait_noack", ufp_ack, 1'b0);
        end
        dfp_ack   = exp_cyc;
        dfp_dat_i = exp_cyc[1] ? {rdat, 32'hBAD0_0000} : {32'hBAD1_1111, rdat};
        tick();
        dfp_ack   = 2'b00;
        dfp_dat_i = 64'h0;
        chk("ufp_ack", ufp_ack, 1'b1);
        chk("ufp_dat", ufp_dat_o, rdat);
        chk("resp_err", bus_err, 1'b0);
        chk("resp_cyc", dfp_cyc, 2'b00);
        drop_req();
        tick();
        chk("ack_clr", ufp_ack, 1'b0);
        chk("dat_clr", ufp_dat_o, 32'h0);
    endtask

    task automatic unmapped(input logic [31:0] adr);
        req(1'b0, adr, 32'h0, 4'hF);
        tick();
        chk("um_ack", ufp_ack, 1'b1);
        chk("um_dat", ufp_dat_o, 32'hDEAD_BEEF);
        chk("um_err", bus_err, 1'b1);
        chk("um_cyc", dfp_cyc, 2'b00);
        drop_req();
        tick();
        chk("um_ack_clr", ufp_ack, 1'b0);
        chk("um_err_clr", bus_err, 1'b0);
    endtask

    initial begin
        logic seen;
        rst       = 1'b1;
        dfp_ack   = 2'b00;
        dfp_dat_i = 64'h0;
        drop_req();
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ack", ufp_ack, 1'b0);
        chk("rst_dat", ufp_dat_o, 32'h0);
        chk("rst_err", bus_err, 1'b0);
        chk("rst_cyc", dfp_cyc, 2'b00);
        chk("rst_adr", dfp_adr, 32'h0);

        // ack while idle is ignored
        dfp_ack   = 2'b01;
        dfp_dat_i = 64'h1;
        tick();
        dfp_ack   = 2'b00;
        dfp_dat_i = 64'h0;
        chk("idle_ack_ignored", ufp_ack, 1'b0);

        xfer(1'b0, 32'h3000_0010, 32'h0, 4'hF, 2'b01, 3, 32'h1234_5678, 1'b0);
        xfer(1'b1, 32'h3010_0004, 32'hA5A5_A5A5, 4'b0011, 2'b10, 2, 32'h0000_00C3, 1'b0);
        unmapped(32'h3030_0000);
        unmapped(32'h2000_0000);

        // back-to-back reads, stray port0 ack during the port1 read
        xfer(1'b0, 32'h3000_0100, 32'h0, 4'hF, 2'b01, 1, 32'h0BAD_F00D, 1'b0);
        xfer(1'b0, 32'h3010_0200, 32'h0, 4'hF, 2'b10, 4, 32'hCAFE_0001, 1'b1);

        // master abort in busy cycle 2
        req(1'b0, 32'h3000_0020, 32'h0, 4'hF);
        tick();
        chk("abort_cyc_pre", dfp_cyc, 2'b01);
        tick();
        drop_req();
        tick();
        chk("abort_cyc", dfp_cyc, 2'b00);
        chk("abort_noack", ufp_ack, 1'b0);
        chk("abort_noerr", bus_err, 1'b0);
        tick();
        chk("abort_noack2", ufp_ack, 1'b0);

        // reset in the middle of a busy write
        req(1'b1, 32'h3010_0008, 32'h5555_AAAA, 4'hC);
        tick();
        chk("rstbusy_cyc_pre", dfp_cyc, 2'b10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drop_req();
        chk("rstbusy_ack", ufp_ack, 1'b0);
        chk("rstbusy_dat", ufp_dat_o, 32'h0);
        chk("rstbusy_err", bus_err, 1'b0);
        chk("rstbusy_cyc", dfp_cyc, 2'b00);
        chk("rstbusy_stb", dfp_stb, 2'b00);
        chk("rstbusy_we", dfp_we, 1'b0);
        chk("rstbusy_sel", dfp_sel, 4'h0);
        chk("rstbusy_wdat", dfp_dat_o, 32'h0);
        chk("rstbusy_adr", dfp_adr, 32'h0);
        tick();
        chk("rstbusy_noack", ufp_ack, 1'b0);
        xfer(1'b0, 32'h3000_0004, 32'h0, 4'hF, 2'b01, 2, 32'h7777_1234, 1'b0);

`ifdef WB_BUS_MUX_TIMEOUT_EN
        req(1'b0, 32'h3000_0000, 32'h0, 4'hF);
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            tick();
            seen = ufp_ack;
        end
        chk("tmo_ack", ufp_ack, 1'b1);
        chk("tmo_dat", ufp_dat_o, 32'hDEAD_BEEF);
        chk("tmo_err", bus_err, 1'b1);
        chk("tmo_cyc", dfp_cyc, 2'b00);
        drop_req();
        tick();
        chk("tmo_ack_clr", ufp_ack, 1'b0);
`else
        req(1'b0, 32'h3000_0000, 32'h0, 4'hF);
        seen = 1'b0;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (ufp_ack || bus_err) seen = 1'b1;
        end
        chk("notmo_noack", seen, 1'b0);
        chk("notmo_cyc", dfp_cyc, 2'b01);
        drop_req();
        tick();
        chk("notmo_abort_cyc", dfp_cyc, 2'b00);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wb_bus_mux_n.md
WB_BUS_MUX_N -- requirements
Module: wb_bus_mux_n

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of downstream Wishbone ports (1..2^SEL_BITS).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h3000_0000, user-area base address.
REQ-003 SHALL have parameter BASE_MASK, default 32'hFF00_0000, bits compared against BASE_ADDR.
REQ-004 SHALL have parameter SEL_LSB, default 20, lowest address bit of the port-select field.
REQ-005 SHALL have parameter SEL_BITS, default 2, width of the port-select field.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 255, downstream wait limit in cycles (1..65535).
REQ-007 SHALL have parameter UNMAPPED_DATA, default 32'hDEAD_BEEF, read data returned on error.
REQ-008 SHALL have wb_clk_i  in  1  single clock; all logic on rising edge.
REQ-009 SHALL have wb_rst_i  in  1  reset, synchronous, active-high.
REQ-010 SHALL have upstream inputs wbs_ufp_stb_i, wbs_ufp_cyc_i, wbs_ufp_we_i (1 each), wbs_ufp_sel_i (4), wbs_ufp_dat_i (32), wbs_ufp_adr_i (32).
REQ-011 SHALL have upstream outputs wbs_ufp_ack_o (1), wbs_ufp_dat_o (32).
REQ-012 SHALL have downstream outputs wbs_dfp_stb_o, wbs_dfp_cyc_o (NUM_PORTS, one bit per port), wbs_dfp_we_o (1), wbs_dfp_sel_o (4), wbs_dfp_dat_o (32), wbs_dfp_adr_o (32), shared by all ports.
REQ-013 SHALL have downstream inputs wbs_dfp_dat_i (32*NUM_PORTS, port p at [32p+31:32p]), wbs_dfp_ack_i (NUM_PORTS).
REQ-014 SHALL have bus_err_o  out  1  one-cycle pulse on unmapped access or timeout.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-016 IDLE: on ufp_cyc&ufp_stb, SHALL decode hit = ((adr & BASE_MASK) == BASE_ADDR) and port = adr[SEL_LSB+SEL_BITS-1:SEL_LSB].
REQ-017 IDLE, hit and port < NUM_PORTS: SHALL latch port, we, sel, dat, adr and at next edge assert stb/cyc of that port only; go BUSY.
REQ-018 IDLE, miss or port >= NUM_PORTS: SHALL go RESP with ack data UNMAPPED_DATA and pulse bus_err_o; no downstream stb/cyc asserted.
REQ-019 BUSY: on wbs_dfp_ack_i[port], SHALL capture that port's dat_i, deassert downstream stb/cyc at next edge, go RESP.
REQ-020 RESP: SHALL drive wbs_ufp_ack_o high exactly one cycle with captured data, then go IDLE.
REQ-021 Latency: request sampled cycle 0, dfp stb cycle 1, dfp ack cycle k, ufp ack cycle k+1; unmapped ack cycle 1.
REQ-022 wbs_ufp_dat_o SHALL be 0 whenever wbs_ufp_ack_o is low; writes return captured value, ignored by master.
REQ-023 BUSY with ufp_cyc low (master abort): SHALL drop downstream stb/cyc next edge, go IDLE, no ack, no bus_err_o.
REQ-024 Acks from non-selected ports, or in IDLE/RESP, SHALL be ignored.
REQ-025 A new request SHALL NOT be accepted in RESP; the earliest acceptance is the cycle after ack.
REQ-026 At most one downstream cyc bit SHALL be high at any time.

Reset
REQ-027 wb_rst_i high at a clock edge SHALL force IDLE, clear timeout counter and latched request, drive all outputs 0 next cycle, including mid-BUSY (no ack issued).

Configuration
REQ-028 Macro WB_BUS_MUX_TIMEOUT_EN defined: 16-bit counter clears on BUSY entry, increments each BUSY cycle; on reaching TIMEOUT_CYCLES without ack SHALL drop downstream stb/cyc, pulse bus_err_o, go RESP with UNMAPPED_DATA.
REQ-029 Macro WB_BUS_MUX_TIMEOUT_EN undefined: no counter synthesised; BUSY waits indefinitely for ack or abort.

Verification
REQ-030 Read adr 32'h3000_0010, port0 ack at cycle 3 with 32'h1234_5678 -> ufp ack cycle 4, dat 32'h1234_5678, only dfp_cyc_o[0] high.
REQ-031 Write adr 32'h3010_0004, dat 32'hA5A5_A5A5, sel 4'b0011 -> dfp_cyc_o=2'b10, dfp dat/sel/we match; ufp ack one cycle after port1 ack.
REQ-032 Read adr 32'h3030_0000 (port 3, NUM_PORTS=2) and 32'h2000_0000 -> ack cycle 1, dat 32'hDEAD_BEEF, bus_err_o pulse, no dfp cyc.
REQ-033 TIMEOUT_EN, TIMEOUT_CYCLES=8, port0 never acks -> dfp cyc drops, ufp ack 32'hDEAD_BEEF, bus_err_o pulse; without macro bench observes no ack after 300 cycles.
REQ-034 Master drops cyc in BUSY cycle 2 -> dfp cyc low next cycle, no ack; wb_rst_i in BUSY -> all outputs 0 next cycle, next request served normally.
REQ-035 Back-to-back reads to ports 0 then 1 with stray port0 ack during port1 transaction -> stray ignored, each read returns its own port's data.
